// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load path.
//   - funct3 load encodings (F3_LB .. F3_LWU)
//   - load_state_e : sequencer states of load_align_unit
//   - legal_load() : is a funct3 a legal load for a given XLEN
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } load_state_e;

  // LD and LWU only exist on RV64; 3'b111 is never a load.
  function automatic logic legal_load(input logic [2:0] f3, input int xlen);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal_load = 1'b1;
      F3_LD, F3_LWU:                       legal_load = (xlen == 64);
      default:                             legal_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Data-memory read bus between load_align_unit (master) and memory (slave).
//   MEM_READ     : read request, held until the word is accepted
//   MEM_ADDR     : word-aligned byte address
//   MEM_RDATA    : read word
//   MEM_BUSYWAIT : memory stall
// Handshake: a word transfers in every cycle with MEM_READ=1 and
// MEM_BUSYWAIT=0; MEM_ADDR is stable while MEM_READ=1 and MEM_BUSYWAIT=1.
interface load_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();

  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [XLEN-1:0]   MEM_RDATA;
  logic              MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_ADDR,
    input  MEM_RDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_ADDR,
    output MEM_RDATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/load_extract.sv
// Combinational load formatter: shifts the two-word window {w1,w0} right by
// the byte offset, keeps 1/2/4/8 bytes per funct3[1:0] and sign- or
// zero-extends per funct3[2].
//   w0, w1 : low / high memory words (w1 = 0 for non-crossing loads)
//   off    : byte offset inside w0
//   funct3 : load type
//   data   : formatted XLEN result
module load_extract #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              w0,
  input  logic [XLEN-1:0]              w1,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              data
);

  localparam int PW = $clog2(2 * XLEN);

  logic [2*XLEN-1:0] pair;
  logic [6:0]        nbits;
  logic [PW-1:0]     msb;
  logic              fill;

  always_comb begin
    pair  = {w1, w0} >> {off, 3'b000};
    nbits = 7'd8 << funct3[1:0];
    msb   = PW'(nbits - 7'd1);
    fill  = ~funct3[2] & pair[msb];
    data  = '0;
    // Bits above the loaded field take the fill (sign or zero).
    for (int i = 0; i < XLEN; i++) begin
      data[i] = (i < int'(nbits)) ? pair[i] : fill;
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts a load (ADDR, FUNCT3), reads one or two
// memory words over mem_bus, formats the result and pulses DONE, or pulses
// LOAD_FAULT for illegal/unsupported-misaligned loads.
//   CLK, RESET      : clock, synchronous active-low reset
//   LOAD_EN         : request strobe (only looked at in IDLE)
//   ADDR, FUNCT3    : byte address and load type
//   DATA_OUT        : formatted result, holds between loads
//   DONE/LOAD_FAULT : one-cycle completion pulses
//   BUSY            : pipeline stall, accepted cycle .. DONE/FAULT cycle
//   mem_bus         : memory read master
//   state_dbg       : current sequencer state
module load_align_unit
  import riscv_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                LOAD_EN,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [2:0]          FUNCT3,
  output logic [XLEN-1:0]     DATA_OUT,
  output logic                DONE,
  output logic                LOAD_FAULT,
  output logic                BUSY,
  load_align_unit_if.master   mem_bus,
  output load_state_e         state_dbg
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   w0_q, w0_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic [OFFW-1:0]   req_off;
  logic [4:0]        req_span;
  logic              req_cross;
  logic              mem_ok;
  logic [XLEN-1:0]   ex_w0, ex_w1, ex_data;

  // Request decode: does OFF+SIZE run past the end of the word?
  always_comb begin
    req_off   = ADDR[OFFW-1:0];
    req_span  = 5'(req_off) + (5'd1 << FUNCT3[1:0]);
    req_cross = (req_span > 5'(NB));
    mem_ok    = ~mem_bus.MEM_BUSYWAIT;
  end

  // The formatter sees the word arriving this cycle so DATA_OUT can be
  // registered on the final capture edge and be valid during RESP.
  always_comb begin
    ex_w0 = (state_q == RD1) ? w0_q : mem_bus.MEM_RDATA;
    ex_w1 = (state_q == RD1) ? mem_bus.MEM_RDATA : '0;
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .w0     (ex_w0),
    .w1     (ex_w1),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ex_data)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      cross_q    <= 1'b0;
      w0_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      cross_q    <= cross_d;
      w0_q       <= w0_d;
      data_q     <= data_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    off_d      = off_q;
    f3_d       = f3_q;
    cross_d    = cross_q;
    w0_d       = w0_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (LOAD_EN) begin
          off_d   = req_off;
          f3_d    = FUNCT3;
          cross_d = req_cross;
          if (!legal_load(FUNCT3, XLEN) || (req_cross && !MISALIGN_SPLIT)) begin
            state_d = FAULT;
          end else begin
            state_d    = RD0;
            mem_addr_d = {ADDR[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          end
        end
      end
      RD0: begin
        if (mem_ok) begin
          w0_d = mem_bus.MEM_RDATA;
          if (cross_q) begin
            state_d    = RD1;
            mem_addr_d = mem_addr_q + ADDR_W'(NB);  // wraps at 2^ADDR_W
          end else begin
            state_d = RESP;
            data_d  = ex_data;
          end
        end
      end
      RD1: begin
        if (mem_ok) begin
          state_d = RESP;
          data_d  = ex_data;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_bus.MEM_READ = (state_q == RD0) || (state_q == RD1);
    mem_bus.MEM_ADDR = mem_addr_q;
    DONE             = (state_q == RESP);
    LOAD_FAULT       = (state_q == FAULT);
    BUSY             = (state_q != IDLE) || LOAD_EN;
    DATA_OUT         = data_q;
    state_dbg        = state_q;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor to the combinational load-data formatter in the MEM stage.
- Accepts a load request (address, funct3), drives the data-memory read handshake, and selects the byte lane from the returned word(s).
- Sign- or zero-extends the result to XLEN and returns it with a done pulse; stalls the pipeline via BUSY while the access is in flight.
- Adds XLEN generalisation, RV64 load types, a memory busy-wait handshake, and split handling of misaligned loads (two word reads merged), or a fault when splitting is disabled.

Parameters:
- XLEN, 32, data/word width in bits (32 or 64).
- ADDR_W, 32, byte-address width.
- MISALIGN_SPLIT, 1, 1 = split word-crossing loads into two reads; 0 = flag LOAD_FAULT, no memory access.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- LOAD_EN  in  1  request strobe, sampled only in IDLE.
- ADDR  in  ADDR_W  byte address of load.
- FUNCT3  in  3  000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- DATA_OUT  out  XLEN  formatted load result.
- DONE  out  1  one-cycle pulse, DATA_OUT valid.
- LOAD_FAULT  out  1  one-cycle pulse: illegal funct3, or misaligned with MISALIGN_SPLIT=0.
- BUSY  out  1  pipeline stall; high from the accepted cycle until the DONE/LOAD_FAULT cycle inclusive.
- MEM_READ  out  1  memory read request.
- MEM_ADDR  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits zero).
- MEM_RDATA  in  XLEN  memory read word.
- MEM_BUSYWAIT  in  1  memory busy; MEM_RDATA valid in the first cycle MEM_READ=1 and MEM_BUSYWAIT=0.

Behaviour:
- Reset (RESET=0 at a clock edge): state=IDLE; DATA_OUT=0, DONE=0, LOAD_FAULT=0, BUSY=0, MEM_READ=0, MEM_ADDR=0; latched request cleared.
- Reset mid-operation aborts immediately; MEM_READ drops on the next edge and the partial word is discarded.
- Definitions: NB=XLEN/8; OFF=ADDR mod NB; SIZE=1<<FUNCT3[1:0]; CROSS = OFF+SIZE > NB.
- IDLE + LOAD_EN:
  - latch ADDR and FUNCT3; BUSY=1.
  - FUNCT3 illegal for XLEN (011/110 with XLEN=32, 111 always): go to FAULT.
  - CROSS with MISALIGN_SPLIT=0: go to FAULT.
  - otherwise go to RD0 with MEM_ADDR = ADDR with low bits cleared.
- RD0: MEM_READ=1. On a cycle with MEM_BUSYWAIT=0, capture W0.
  - CROSS: go to RD1 with MEM_ADDR += NB; the address wraps modulo 2^ADDR_W.
  - not CROSS: go to RESP.
- RD1: MEM_READ=1. On a cycle with MEM_BUSYWAIT=0, capture W1 and go to RESP.
- MEM_READ deasserts in the cycle after the final capture. There is no gap cycle between RD0 and RD1: MEM_READ stays high.
- RESP: DATA_OUT = extend(({W1,W0} >> 8*OFF)[8*SIZE-1:0]), with W1=0 when not CROSS.
  - Extension is sign when FUNCT3[2]=0, zero otherwise.
  - DONE=1 for one cycle; BUSY=1 this cycle; return to IDLE.
- FAULT: LOAD_FAULT=1 for one cycle, DATA_OUT unchanged, no memory access; return to IDLE.
- DATA_OUT holds its last value between loads.
- LOAD_EN asserted outside IDLE is ignored; the pipeline is stalled by BUSY.
- Latency with zero wait states: aligned = 3 edges from LOAD_EN to DONE; split = 4 edges.
- MEM_BUSYWAIT held high extends RD0/RD1 indefinitely; there is no timeout.
- LD (XLEN=64, SIZE=8, OFF=0) never crosses; LW at OFF=0 with XLEN=32 never crosses.

Decomposition:
- Shared package riscv_mem_pkg:
  - funct3 load encodings (F3_LB … F3_LWU).
  - state enum {IDLE, RD0, RD1, RESP, FAULT}.
  - function legal_load(funct3, xlen).
- Sub-module load_extract (combinational): {W1,W0}, OFF, FUNCT3 → DATA_OUT. Reused by the future store-alignment block's readback check.

Test Plan:
- XLEN=32, MEM_RDATA=0x0000CC66, no waits:
  - LB @0x100 → DONE at 3rd edge, DATA_OUT=0x00000066.
  - LH @0x100 → 0x0000CC66? No: sign bit of 0xCC66 set → 0xFFFFCC66.
  - LHU @0x100 → 0x0000CC66.
  - LW @0x100 → 0x0000CC66.
- Byte lanes, word 0x8899AABB:
  - LB @0x103 → 0xFFFFFF88.
  - LBU @0x102 → 0x00000099.
  - LH @0x102 → 0xFFFF8899.
- Split, word@0x100=0x8899AABB, word@0x104=0x11223344, MISALIGN_SPLIT=1:
  - LW @0x102 → MEM_ADDR 0x100 then 0x104, MEM_READ continuous for 2 cycles, DONE at 4th edge, DATA_OUT=0x33448899.
- MEM_BUSYWAIT high 5 cycles in RD0 → MEM_ADDR and MEM_READ stable throughout, BUSY high, DONE 5 cycles later, correct data.
- Faults (XLEN=32):
  - MISALIGN_SPLIT=0, LH @0x103 → LOAD_FAULT pulse at 2nd edge, MEM_READ never asserted.
  - FUNCT3=011 → LOAD_FAULT.
- RESET=0 during RD1 wait → next edge: MEM_READ=0, BUSY=0, no DONE.
  - New LBU @0x101 after reset → 0x000000AA.
- XLEN=64, word 0xF0E0D0C0B0A09080:
  - LWU @0x4 → 0x00000000F0E0D0C0.
  - LW @0x4 → 0xFFFFFFFFF0E0D0C0.
  - LD @0x0 → full word.
